// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Arbitrates the program ROM between the instruction fetch unit and a UART
// program loader.
//
//   RUN  : fetch_addr passes straight to the ROM; the CPU runs.
//   LOAD : the CPU is held in reset; received bytes are packed little-endian
//          into 32-bit words and written to consecutive ROM words from 0.
//   DONE : the byte stream went idle for TIMEOUT cycles; CPU still held until
//          the mode switch is released, after which it restarts from PC 0.
//
// Ports
//   clock        in   system clock, all state changes on posedge
//   reset        in   asynchronous active-low reset
//   mode_req     in   1 = request program-load mode
//   rx_valid     in   one-cycle strobe qualifying rx_byte
//   rx_byte      in   received UART byte
//   fetch_addr   in   fetch word address (PC[15:2])
//   rom_addr     out  ROM word address
//   rom_we       out  ROM write enable (one cycle per completed word)
//   rom_wdata    out  ROM write data
//   cpu_hold     out  1 = hold fetch unit and CPU in reset
//   load_done    out  load finished by idle timeout
//   words_loaded out  words written in the current or last load
//   err_overflow out  bytes arrived after DEPTH words were written
//   err_partial  out  load ended with 1-3 bytes of an unfinished word
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 16384,
  parameter int TIMEOUT = 10000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_overflow,
  output logic              err_partial
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TMO_MAX  = TCNT_W'(TIMEOUT);
  localparam logic [ADDR_W+1:0] DEPTH_C  = (ADDR_W + 2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_byte_idx;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [ADDR_W:0]     r_words;      // doubles as the ROM word pointer
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_seen;       // at least one byte received this load
  logic                r_load_done;
  logic                r_err_ovf;
  logic                r_err_partial;

  logic                w_enter;
  logic                w_rx_act;
  logic [ADDR_W+1:0]   w_fill;
  logic                w_full;
  logic                w_take;
  logic                w_drop_ovf;
  logic                w_last;
  logic                w_exit;
  logic                w_tmo;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign w_enter  = (r_state == ST_RUN) && mode_req;

  // A byte that coincides with mode_req=0 is dropped: the exit wins.
  assign w_rx_act = (r_state == ST_LOAD) && rx_valid && mode_req;

  // Count a word whose write pulse is in flight as already written, so a byte
  // immediately following the final word is correctly treated as overflow.
  assign w_fill   = {1'b0, r_words} + {{(ADDR_W + 1){1'b0}}, r_we};
  assign w_full   = (w_fill >= DEPTH_C);

  assign w_take     = w_rx_act && !w_full;
  assign w_drop_ovf = w_rx_act && w_full;
  assign w_last     = w_take && (r_byte_idx == 2'd3);

  // A write pulse in flight defers the exit by one cycle so words_loaded and
  // the pointer settle on the completed word.
  assign w_exit = (r_state == ST_LOAD) && !mode_req && !r_we;

  assign w_tmo  = (r_state == ST_LOAD) && mode_req && !rx_valid && !r_we &&
                  r_seen && (r_tcnt >= TMO_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment on entry to every always_comb guarantees
  // each path drives w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (mode_req) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (w_exit)     w_state_nxt = ST_RUN;
        else if (w_tmo) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (!mode_req) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing, counters and status
  // ---------------------------------------------------------------------------
  // NOTE: the ROM array lives outside this block; only the control registers
  // here are reset, so an aborted load leaves already-written words intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_idx    <= 2'd0;
      r_wdata       <= 32'd0;
      r_we          <= 1'b0;
      r_words       <= '0;
      r_tcnt        <= '0;
      r_seen        <= 1'b0;
      r_load_done   <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_partial <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register below sample the
      // pre-edge values, independent of statement order.
      r_we <= w_last;

      if (w_enter) begin
        r_byte_idx    <= 2'd0;
        r_words       <= '0;
        r_tcnt        <= '0;
        r_seen        <= 1'b0;
        r_load_done   <= 1'b0;
        r_err_ovf     <= 1'b0;
        r_err_partial <= 1'b0;
      end else begin
        if (w_take) begin
          r_wdata[{r_byte_idx, 3'b000} +: 8] <= rx_byte;
          r_byte_idx <= r_byte_idx + 2'd1;   // wraps 3 -> 0 on the last byte
        end else if (w_exit || w_tmo) begin
          r_byte_idx <= 2'd0;                // pending bytes are discarded
        end

        if (r_we) begin
          r_words <= r_words + 1'b1;
        end

        // Any received byte, even a discarded overflow byte, is activity.
        if (w_rx_act) begin
          r_tcnt <= '0;
          r_seen <= 1'b1;
        end else if ((r_state == ST_LOAD) && r_seen && (r_tcnt != TMO_MAX)) begin
          r_tcnt <= r_tcnt + 1'b1;
        end

        if (w_drop_ovf) begin
          r_err_ovf <= 1'b1;
        end

        if ((w_exit || w_tmo) && (r_byte_idx != 2'd0)) begin
          r_err_partial <= 1'b1;
        end

        if (w_tmo) begin
          r_load_done <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_addr     = (r_state == ST_RUN) ? fetch_addr : r_words[ADDR_W-1:0];
  assign rom_we       = r_we;
  assign rom_wdata    = r_wdata;
  assign cpu_hold     = (r_state != ST_RUN);
  assign load_done    = r_load_done;
  assign words_loaded = r_words;
  assign err_overflow = r_err_ovf;
  assign err_partial  = r_err_partial;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Directed bench for imem_load_ctrl. Two instances share the stimulus: one
// with room for 16 words, one limited to 2 words for the overflow case. Both
// use a 16-cycle idle timeout. ROM writes are captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              mode_req;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] fetch_addr;

  logic [ADDR_W-1:0] rom_addr,     rom_addr2;
  logic              rom_we,       rom_we2;
  logic [31:0]       rom_wdata,    rom_wdata2;
  logic              cpu_hold,     cpu_hold2;
  logic              load_done,    load_done2;
  logic [ADDR_W:0]   words_loaded, words_loaded2;
  logic              err_overflow, err_overflow2;
  logic              err_partial,  err_partial2;

  int n_checks = 0;
  int n_err    = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [31:0]       q_data[$];
  logic [ADDR_W-1:0] q_addr2[$];
  logic [31:0]       q_data2[$];

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DEPTH(16), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .mode_req(mode_req), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .fetch_addr(fetch_addr), .rom_addr(rom_addr),
    .rom_we(rom_we), .rom_wdata(rom_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .words_loaded(words_loaded),
    .err_overflow(err_overflow), .err_partial(err_partial)
  );

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DEPTH(2), .TIMEOUT(16)) dut_small (
    .clock(clock), .reset(reset), .mode_req(mode_req), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .fetch_addr(fetch_addr), .rom_addr(rom_addr2),
    .rom_we(rom_we2), .rom_wdata(rom_wdata2), .cpu_hold(cpu_hold2),
    .load_done(load_done2), .words_loaded(words_loaded2),
    .err_overflow(err_overflow2), .err_partial(err_partial2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rom_we === 1'b1) begin
      q_addr.push_back(rom_addr);
      q_data.push_back(rom_wdata);
    end
    if (rom_we2 === 1'b1) begin
      q_addr2.push_back(rom_addr2);
      q_data2.push_back(rom_wdata2);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    mode_req   = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    fetch_addr = 4'h5;

    // ---- Reset and pass-through ----
    #3;
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_rom_we", 64'(rom_we), 64'd0);
    #20;
    reset = 1'b1;
    tick();
    check("pt_rom_addr", 64'(rom_addr), 64'h5);
    check("pt_rom_we", 64'(rom_we), 64'd0);
    check("pt_cpu_hold", 64'(cpu_hold), 64'd0);
    check("pt_flags", 64'({load_done, err_overflow, err_partial}), 64'd0);
    check("pt_words", 64'(words_loaded), 64'd0);
    check("pt_wdata", 64'(rom_wdata), 64'd0);

    // ---- Single word load ----
    mode_req = 1'b1;
    tick();
    check("sw_hold_first", 64'(cpu_hold), 64'd1);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    check("sw_no_early_we", 64'(rom_we), 64'd0);
    send_byte(8'h01);
    check("sw_we", 64'(rom_we), 64'd1);
    check("sw_addr", 64'(rom_addr), 64'd0);
    check("sw_wdata", 64'(rom_wdata), 64'h0100_0820);
    check("sw_words_before", 64'(words_loaded), 64'd0);
    tick();
    check("sw_we_one_cycle", 64'(rom_we), 64'd0);
    check("sw_words", 64'(words_loaded), 64'd1);
    check("sw_hold", 64'(cpu_hold), 64'd1);
    check("sw_nwrites", 64'(q_addr.size()), 64'd1);

    mode_req = 1'b0;
    tick();
    check("sw_exit_hold", 64'(cpu_hold), 64'd0);

    // ---- Back-to-back stream and timeout ----
    q_addr.delete(); q_data.delete(); q_addr2.delete(); q_data2.delete();
    mode_req = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i));
    repeat (8) tick();
    check("bb_nwrites", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) begin
      check("bb_addr0", 64'(q_addr[0]), 64'd0);
      check("bb_addr1", 64'(q_addr[1]), 64'd1);
      check("bb_addr2", 64'(q_addr[2]), 64'd2);
      check("bb_data0", 64'(q_data[0]), 64'h1312_1110);
      check("bb_data1", 64'(q_data[1]), 64'h1716_1514);
      check("bb_data2", 64'(q_data[2]), 64'h1B1A_1918);
    end
    check("bb_words", 64'(words_loaded), 64'd3);
    check("bb_not_done_yet", 64'(load_done), 64'd0);
    repeat (12) tick();
    check("bb_load_done", 64'(load_done), 64'd1);
    check("bb_done_hold", 64'(cpu_hold), 64'd1);
    check("bb_no_partial", 64'(err_partial), 64'd0);

    mode_req   = 1'b0;
    fetch_addr = 4'h9;
    tick();
    check("bb_run_hold", 64'(cpu_hold), 64'd0);
    check("bb_run_addr", 64'(rom_addr), 64'h9);
    check("bb_done_kept", 64'(load_done), 64'd1);
    check("bb_words_kept", 64'(words_loaded), 64'd3);

    // A byte in RUN is ignored.
    send_byte(8'hFF);
    tick();
    check("run_ignore_words", 64'(words_loaded), 64'd3);
    check("run_ignore_we", 64'(q_addr.size()), 64'd3);

    // ---- Partial word and abort ----
    q_addr.delete(); q_data.delete(); q_addr2.delete(); q_data2.delete();
    mode_req = 1'b1;
    tick();
    check("pa_done_cleared", 64'(load_done), 64'd0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    mode_req = 1'b0;
    tick();
    check("pa_exit_hold", 64'(cpu_hold), 64'd0);
    check("pa_err_partial", 64'(err_partial), 64'd1);
    check("pa_words", 64'(words_loaded), 64'd1);
    repeat (3) tick();
    check("pa_nwrites", 64'(q_addr.size()), 64'd1);
    if (q_addr.size() == 1) begin
      check("pa_addr0", 64'(q_addr[0]), 64'd0);
      check("pa_data0", 64'(q_data[0]), 64'hA3A2_A1A0);
    end

    // Second load: flags clear, writes restart at 0, exit with pulse pending.
    mode_req = 1'b1;
    tick();
    check("pa2_partial_clr", 64'(err_partial), 64'd0);
    check("pa2_words_clr", 64'(words_loaded), 64'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    mode_req = 1'b0;
    tick();
    check("pa2_exit_deferred", 64'(cpu_hold), 64'd1);
    check("pa2_words", 64'(words_loaded), 64'd1);
    tick();
    check("pa2_exit_taken", 64'(cpu_hold), 64'd0);
    check("pa2_no_partial", 64'(err_partial), 64'd0);
    check("pa2_nwrites", 64'(q_addr.size()), 64'd2);
    if (q_addr.size() == 2) begin
      check("pa2_addr", 64'(q_addr[1]), 64'd0);
      check("pa2_data", 64'(q_data[1]), 64'h8877_6655);
    end

    // ---- Overflow on the 2-word instance ----
    q_addr.delete(); q_data.delete(); q_addr2.delete(); q_data2.delete();
    mode_req = 1'b1;
    tick();
    check("ov_ovf_clr", 64'(err_overflow2), 64'd0);
    for (int i = 0; i < 12; i++) send_byte(8'h30 + 8'(i));
    repeat (2) tick();
    check("ov_nwrites", 64'(q_addr2.size()), 64'd2);
    if (q_addr2.size() == 2) begin
      check("ov_addr0", 64'(q_addr2[0]), 64'd0);
      check("ov_addr1", 64'(q_addr2[1]), 64'd1);
      check("ov_data0", 64'(q_data2[0]), 64'h3332_3130);
      check("ov_data1", 64'(q_data2[1]), 64'h3736_3534);
    end
    check("ov_err", 64'(err_overflow2), 64'd1);
    check("ov_words", 64'(words_loaded2), 64'd2);
    check("ov_big_no_err", 64'(err_overflow), 64'd0);
    check("ov_big_words", 64'(words_loaded), 64'd3);
    mode_req = 1'b0;
    tick();

    // ---- Async reset mid-word ----
    q_addr.delete(); q_data.delete(); q_addr2.delete(); q_data2.delete();
    mode_req = 1'b1;
    tick();
    send_byte(8'hC1);
    send_byte(8'hC2);
    mode_req = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("ar_hold", 64'(cpu_hold), 64'd0);
    check("ar_we", 64'(rom_we), 64'd0);
    check("ar_wdata", 64'(rom_wdata), 64'd0);
    check("ar_words", 64'(words_loaded), 64'd0);
    #7;
    reset = 1'b1;
    repeat (2) tick();
    check("ar_run_hold", 64'(cpu_hold), 64'd0);
    check("ar_run_addr", 64'(rom_addr), 64'h9);
    check("ar_no_write", 64'(q_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences ownership of the program ROM (prgrom) between the instruction fetch unit and a UART program loader.
- In run mode, the fetch word address passes straight through to the ROM and the CPU runs.
- In load mode, the CPU is held in reset. Incoming UART bytes are packed into 32-bit words and written sequentially from ROM word 0. On exit, the CPU restarts from PC 0.

Parameters:
ADDR_W, 14, ROM word-address width (matches PC[15:2])
DEPTH, 16384, number of writable ROM words; must be <= 2^ADDR_W
TIMEOUT, 10000000, idle cycles after the last byte before the load is declared complete

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (block is in reset while 0)
mode_req  input  1  board switch; 1 = request program-load mode
rx_valid  input  1  one-cycle strobe: rx_byte valid
rx_byte  input  8  received UART byte
fetch_addr  input  ADDR_W  fetch word address from the fetch unit (PC[15:2])
rom_addr  output  ADDR_W  ROM address
rom_we  output  1  ROM write enable
rom_wdata  output  32  ROM write data
cpu_hold  output  1  1 = hold the fetch unit and CPU in reset
load_done  output  1  load completed by timeout
words_loaded  output  ADDR_W+1  number of words written in the current or last load
err_overflow  output  1  bytes arrived after DEPTH words were written
err_partial  output  1  load ended with 1-3 bytes of an incomplete word pending

Behaviour:
- Reset (reset=0, async):
  - state=RUN, rom_we=0, rom_wdata=0, cpu_hold=0, load_done=0, words_loaded=0, both error flags=0.
  - Byte index, word pointer and timeout counter are cleared.
  - Reset mid-load aborts the load immediately. ROM contents already written stay; no partial word is written.
- States: RUN, LOAD, DONE.
- RUN:
  - rom_addr = fetch_addr (combinational), rom_we=0, cpu_hold=0, rx_valid ignored.
  - mode_req=1 sampled -> LOAD. On entry: word pointer, byte index, timeout counter, words_loaded and error flags clear; load_done clears.
- LOAD:
  - cpu_hold=1 (combinational from state, so it asserts in the first LOAD cycle).
  - rom_addr = word pointer (registered).
- Byte packing (LOAD), little-endian:
  - Byte k of a word goes to wdata[8k+7:8k], k=0..3.
  - The 4th byte accepted at edge N -> rom_we=1 for exactly the one cycle after edge N, with the complete word and its address.
  - Word pointer and words_loaded increment at edge N+1; byte index wraps to 0.
  - Back-to-back rx_valid every cycle is supported; no byte is lost.
- Overflow (LOAD): when words_loaded==DEPTH, further bytes are discarded, err_overflow sets and stays set. No ROM address wrap-around.
- Timeout counter (LOAD):
  - Resets to 0 on every accepted byte; increments otherwise.
  - Counts only after at least one byte has been received; an idle LOAD with zero bytes never times out.
  - Reaching TIMEOUT -> DONE. If byte index != 0 at that point, err_partial sets and the pending bytes are discarded.
- DONE: cpu_hold=1, load_done=1, rx_valid ignored, rom_we=0.
- Exit from LOAD or DONE:
  - mode_req=0 sampled -> RUN. cpu_hold deasserts in the first RUN cycle.
  - Leaving LOAD with byte index != 0 sets err_partial.
- Simultaneous events:
  - rx_valid in the same cycle mode_req is sampled 0 in LOAD: the byte is dropped and the exit wins.
  - A 4th byte arriving in the same cycle as timeout expiry cannot occur, because the byte resets the counter; the byte wins.
  - A write pulse pending at the exit edge is still issued, and the exit is taken one cycle later.
- load_done, words_loaded and the error flags hold their values in RUN until the next LOAD entry.

Test Plan:
- Reset and pass-through: reset=0 then 1; fetch_addr=0x0005 -> rom_addr=0x0005, rom_we=0, cpu_hold=0, all flags 0.
- Single word load: mode_req=1; bytes 0x20,0x08,0x00,0x01 -> one rom_we pulse the cycle after the 4th byte, rom_addr=0, rom_wdata=0x01000820, words_loaded=1, cpu_hold=1.
- Back-to-back stream, TIMEOUT=16: 12 bytes on consecutive cycles -> 3 writes at addr 0,1,2; 16 idle cycles later load_done=1. mode_req=0 -> RUN, cpu_hold=0, rom_addr follows fetch_addr.
- Partial and abort: 6 bytes then mode_req=0 -> one write at addr 0, err_partial=1, no write at addr 1. A second load clears err_partial, and its first word goes to addr 0.
- Overflow, DEPTH=2: 12 bytes -> writes at addr 0 and 1 only, err_overflow=1, words_loaded=2.
- Async reset mid-word: reset=0 after 2 bytes, between clock edges -> outputs reset immediately, no rom_we; after release the block is in RUN.
